// File: rtl/timer_host_pkg.sv
// Shared types and constants for the interval-timer host sequencer.
// The snapshot path is included only when TIMER_HOST_SNAPSHOT_EN is defined.
package timer_host_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_PL    = 4'd1,
    WR_PH    = 4'd2,
    WR_CTRL  = 4'd3,
    WAIT_IRQ = 4'd4,
    CLR_STAT = 4'd5,
    SNAP     = 4'd6,
    RD_SL    = 4'd7,
    RD_SH    = 4'd8,
    TICK     = 4'd9,
    WR_STOP  = 4'd10
  } state_e;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, wdata: 16'h0000};

  function automatic bus_t bus_wr(input logic [2:0] addr, input logic [15:0] data);
    bus_wr = '{cs: 1'b1, write_n: 1'b0, addr: addr, wdata: data};
  endfunction

  function automatic bus_t bus_rd(input logic [2:0] addr);
    bus_rd = '{cs: 1'b1, write_n: 1'b1, addr: addr, wdata: 16'h0000};
  endfunction

  function automatic logic [15:0] ctrl_run_word(input logic cont);
    logic [15:0] w;
    w = 16'h0000;
    w[CTRL_ITO]   = 1'b1;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/timer_host_seq.sv
// Avalon-MM initiator that programs an interval timer, services its timeouts and
// stops it on request. Define TIMER_HOST_SNAPSHOT_EN to add the counter snapshot path.
module timer_host_seq
  import timer_host_pkg::*;
#(
  parameter logic [31:0] PERIOD     = 32'h02FAF07F,
  parameter logic        CONTINUOUS = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  output logic [2:0]  tm_address,
  output logic        tm_chipselect,
  output logic        tm_write_n,
  output logic [15:0] tm_writedata,
  input  logic [15:0] tm_readdata,
  input  logic        tm_irq,
  output logic        busy,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic [31:0] snapshot
);

  state_e      state_q, state_d;
  logic        stop_pend_q, stop_pend_d;
  logic        stop_now_s;
  bus_t        bus_q, bus_d;
  logic        tick_q, tick_d;
  logic [15:0] tick_count_q, tick_count_d;

  // Next state: a stop (new or latched) is honoured when the current access ends.
  always_comb begin
    state_d     = state_q;
    stop_now_s  = stop_pend_q | stop;
    stop_pend_d = stop_now_s;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        state_d     = start ? WR_PL : IDLE;
      end
      WR_PL:    state_d = stop_now_s ? WR_STOP : WR_PH;
      WR_PH:    state_d = stop_now_s ? WR_STOP : WR_CTRL;
      WR_CTRL:  state_d = stop_now_s ? WR_STOP : WAIT_IRQ;
      WAIT_IRQ: state_d = stop_now_s ? WR_STOP : (tm_irq ? CLR_STAT : WAIT_IRQ);
`ifdef TIMER_HOST_SNAPSHOT_EN
      CLR_STAT: state_d = stop_now_s ? WR_STOP : SNAP;
      SNAP:     state_d = stop_now_s ? WR_STOP : RD_SL;
      RD_SL:    state_d = stop_now_s ? WR_STOP : RD_SH;
      RD_SH:    state_d = stop_now_s ? WR_STOP : TICK;
`else
      CLR_STAT: state_d = stop_now_s ? WR_STOP : TICK;
`endif
      TICK:     state_d = stop_now_s ? WR_STOP : (CONTINUOUS ? WAIT_IRQ : IDLE);
      WR_STOP: begin
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    // Bus outputs are registered from the next state so they line up with state_q.
    case (state_d)
      WR_PL:    bus_d = bus_wr(ADDR_PERIOD_L, PERIOD[15:0]);
      WR_PH:    bus_d = bus_wr(ADDR_PERIOD_H, PERIOD[31:16]);
      WR_CTRL:  bus_d = bus_wr(ADDR_CONTROL, ctrl_run_word(CONTINUOUS));
      CLR_STAT: bus_d = bus_wr(ADDR_STATUS, 16'h0000);
      SNAP:     bus_d = bus_wr(ADDR_SNAP_L, 16'h0000);
      RD_SL:    bus_d = bus_rd(ADDR_SNAP_L);
      RD_SH:    bus_d = bus_rd(ADDR_SNAP_H);
      WR_STOP:  bus_d = bus_wr(ADDR_CONTROL, 16'h0001 << CTRL_STOP);
      default:  bus_d = BUS_IDLE;
    endcase

    tick_d       = (state_d == TICK);
    tick_count_d = tick_d ? (tick_count_q + 16'd1) : tick_count_q;
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      stop_pend_q  <= 1'b0;
      bus_q        <= BUS_IDLE;
      tick_q       <= 1'b0;
      tick_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      stop_pend_q  <= stop_pend_d;
      bus_q        <= bus_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
    end
  end

`ifdef TIMER_HOST_SNAPSHOT_EN
  logic [31:0] snapshot_q, snapshot_d;

  // Read data lags the address by one cycle: low half lands during RD_SH, high during TICK.
  always_comb begin
    snapshot_d = snapshot_q;
    if (state_q == RD_SH) begin
      snapshot_d[15:0] = tm_readdata;
    end else if (state_q == TICK) begin
      snapshot_d[31:16] = tm_readdata;
    end else begin
      snapshot_d = snapshot_q;
    end
  end

  // Snapshot register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snapshot_q <= 32'h0000_0000;
    end else begin
      snapshot_q <= snapshot_d;
    end
  end

  assign snapshot = snapshot_q;
`else
  logic unused_readdata;
  assign unused_readdata = ^tm_readdata;
  assign snapshot        = 32'h0000_0000;
`endif

  assign tm_chipselect = bus_q.cs;
  assign tm_write_n    = bus_q.write_n;
  assign tm_address    = bus_q.addr;
  assign tm_writedata  = bus_q.wdata;
  assign busy          = (state_q != IDLE);
  assign tick          = tick_q;
  assign tick_count    = tick_count_q;

endmodule

// File: tb/tb_timer_host_seq.sv
// Directed bench for timer_host_seq: vector table for the continuous instance, plus
// hand-written reset and one-shot sequences. Follows TIMER_HOST_SNAPSHOT_EN like the RTL.
module tb_timer_host_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop, irq;
  logic [15:0] rdata;
  logic [2:0]  addr;
  logic        cs, wr_n, busy, tick;
  logic [15:0] wdata, cnt;
  logic [31:0] snap;

  logic        os_start, os_irq;
  logic [2:0]  os_addr;
  logic        os_cs, os_wr_n, os_busy, os_tick;
  logic [15:0] os_wdata, os_cnt;
  logic [31:0] os_snap;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timer_host_seq #(.PERIOD(32'd99), .CONTINUOUS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .tm_address(addr), .tm_chipselect(cs), .tm_write_n(wr_n), .tm_writedata(wdata),
    .tm_readdata(rdata), .tm_irq(irq), .busy(busy), .tick(tick),
    .tick_count(cnt), .snapshot(snap)
  );

  timer_host_seq #(.PERIOD(32'd99), .CONTINUOUS(1'b0)) dut_os (
    .clk(clk), .reset_n(reset_n), .start(os_start), .stop(1'b0),
    .tm_address(os_addr), .tm_chipselect(os_cs), .tm_write_n(os_wr_n), .tm_writedata(os_wdata),
    .tm_readdata(16'h0000), .tm_irq(os_irq), .busy(os_busy), .tick(os_tick),
    .tick_count(os_cnt), .snapshot(os_snap)
  );

`ifdef TIMER_HOST_SNAPSHOT_EN
  localparam logic [31:0] SN1 = 32'h0000_0062;
  localparam logic [31:0] SN2 = 32'h0001_0061;
`else
  localparam logic [31:0] SN1 = 32'h0000_0000;
  localparam logic [31:0] SN2 = 32'h0000_0000;
`endif

  typedef struct {
    logic        start, stop, irq;
    logic [15:0] rdata;
    logic        cs, wr_n;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic        busy, tick;
    logic [15:0] cnt;
    logic [31:0] snap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic st, input logic sp, input logic iq, input logic [15:0] rd,
                             input logic c, input logic wn, input logic [2:0] ad, input logic [15:0] wd,
                             input logic bz, input logic tk, input logic [15:0] ct, input logic [31:0] sn);
    vec_t r;
    r.start = st; r.stop = sp; r.irq = iq; r.rdata = rd;
    r.cs = c; r.wr_n = wn; r.addr = ad; r.wdata = wd;
    r.busy = bz; r.tick = tk; r.cnt = ct; r.snap = sn;
    return r;
  endfunction

  function automatic logic [95:0] obs();
    return {25'd0, cs, wr_n, addr, wdata, busy, tick, cnt, snap};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int ticks;

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; irq = 1'b0; rdata = 16'h0000;
    os_start = 1'b0; os_irq = 1'b0;

    // programming, two timeouts, stop with simultaneous irq, idle behaviour
    vecs.push_back(v(1'b1,1'b0,1'b0,16'h0000, 1'b1,1'b0,3'd2,16'h0063, 1'b1,1'b0,16'd0,32'h0));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,3'd3,16'h0000, 1'b1,1'b0,16'd0,32'h0));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,3'd1,16'h0007, 1'b1,1'b0,16'd0,32'h0));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b1,3'd0,16'h0000, 1'b1,1'b0,16'd0,32'h0));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b1,3'd0,16'h0000, 1'b1,1'b0,16'd0,32'h0));
    vecs.push_back(v(1'b0,1'b0,1'b1,16'h0000, 1'b1,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'd0,32'h0));
`ifdef TIMER_HOST_SNAPSHOT_EN
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,3'd4,16'h0000, 1'b1,1'b0,16'd0,32'h0));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b1,3'd4,16'h0000, 1'b1,1'b0,16'd0,32'h0));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'hDEAD, 1'b1,1'b1,3'd5,16'h0000, 1'b1,1'b0,16'd0,32'h0));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0062, 1'b0,1'b1,3'd0,16'h0000, 1'b1,1'b1,16'd1,32'h0000_0062));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b1,3'd0,16'h0000, 1'b1,1'b0,16'd1,SN1));
    vecs.push_back(v(1'b0,1'b0,1'b1,16'h0000, 1'b1,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'd1,SN1));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,3'd4,16'h0000, 1'b1,1'b0,16'd1,SN1));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b1,3'd4,16'h0000, 1'b1,1'b0,16'd1,SN1));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'hBEEF, 1'b1,1'b1,3'd5,16'h0000, 1'b1,1'b0,16'd1,SN1));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0061, 1'b0,1'b1,3'd0,16'h0000, 1'b1,1'b1,16'd2,32'h0000_0061));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0001, 1'b0,1'b1,3'd0,16'h0000, 1'b1,1'b0,16'd2,SN2));
`else
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b1,3'd0,16'h0000, 1'b1,1'b1,16'd1,32'h0));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b1,3'd0,16'h0000, 1'b1,1'b0,16'd1,32'h0));
    vecs.push_back(v(1'b0,1'b0,1'b1,16'h0000, 1'b1,1'b0,3'd0,16'h0000, 1'b1,1'b0,16'd1,32'h0));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b1,3'd0,16'h0000, 1'b1,1'b1,16'd2,32'h0));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b1,3'd0,16'h0000, 1'b1,1'b0,16'd2,32'h0));
`endif
    vecs.push_back(v(1'b0,1'b1,1'b1,16'h0000, 1'b1,1'b0,3'd1,16'h0008, 1'b1,1'b0,16'd2,SN2));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b1,3'd0,16'h0000, 1'b0,1'b0,16'd2,SN2));
    vecs.push_back(v(1'b0,1'b1,1'b0,16'h0000, 1'b0,1'b1,3'd0,16'h0000, 1'b0,1'b0,16'd2,SN2));
    vecs.push_back(v(1'b0,1'b0,1'b1,16'h0000, 1'b0,1'b1,3'd0,16'h0000, 1'b0,1'b0,16'd2,SN2));
    // restart; start while busy is ignored; stop during WR_PH ends at WR_STOP
    vecs.push_back(v(1'b1,1'b0,1'b0,16'h0000, 1'b1,1'b0,3'd2,16'h0063, 1'b1,1'b0,16'd2,SN2));
    vecs.push_back(v(1'b1,1'b0,1'b0,16'h0000, 1'b1,1'b0,3'd3,16'h0000, 1'b1,1'b0,16'd2,SN2));
    vecs.push_back(v(1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b0,3'd1,16'h0008, 1'b1,1'b0,16'd2,SN2));
    vecs.push_back(v(1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b1,3'd0,16'h0000, 1'b0,1'b0,16'd2,SN2));

    step();
    chk("reset_state", obs(), {25'd0, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 16'd0, 32'h0});
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; stop = vecs[i].stop; irq = vecs[i].irq; rdata = vecs[i].rdata;
      step();
      chk($sformatf("row%0d", i), obs(),
          {25'd0, vecs[i].cs, vecs[i].wr_n, vecs[i].addr, vecs[i].wdata,
           vecs[i].busy, vecs[i].tick, vecs[i].cnt, vecs[i].snap});
    end
    start = 1'b0; stop = 1'b0; irq = 1'b0; rdata = 16'h0000;

    // reset in the middle of a timeout service
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    irq = 1'b1; step(); irq = 1'b0;
`ifdef TIMER_HOST_SNAPSHOT_EN
    step(); step();
    chk("pre_reset_rd_sl", {91'd0, cs, wr_n, addr}, {91'd0, 1'b1, 1'b1, 3'd4});
`else
    chk("pre_reset_clr", {91'd0, cs, wr_n, addr}, {91'd0, 1'b1, 1'b0, 3'd0});
`endif
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset", obs(), {25'd0, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 16'd0, 32'h0});
    @(negedge clk);
    reset_n = 1'b1;
    irq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("no_access_%0d", i), {94'd0, cs, busy}, 96'd0);
    end
    irq = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("restart_pl", {75'd0, cs, wr_n, addr, wdata}, {75'd0, 1'b1, 1'b0, 3'd2, 16'h0063});

    // one-shot instance
    os_start = 1'b1; step(); os_start = 1'b0;
    chk("os_pl", {75'd0, os_cs, os_wr_n, os_addr, os_wdata}, {75'd0, 1'b1, 1'b0, 3'd2, 16'h0063});
    step();
    chk("os_ph", {75'd0, os_cs, os_wr_n, os_addr, os_wdata}, {75'd0, 1'b1, 1'b0, 3'd3, 16'h0000});
    step();
    chk("os_ctrl", {75'd0, os_cs, os_wr_n, os_addr, os_wdata}, {75'd0, 1'b1, 1'b0, 3'd1, 16'h0005});
    step();
    os_irq = 1'b1; step(); os_irq = 1'b0;
    chk("os_clr", {75'd0, os_cs, os_wr_n, os_addr, os_wdata}, {75'd0, 1'b1, 1'b0, 3'd0, 16'h0000});
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (os_tick) ticks++;
    end
    chk("os_ticks", 96'(ticks), 96'd1);
    chk("os_end", {78'd0, os_busy, os_cs, os_cnt}, {78'd0, 1'b0, 1'b0, 16'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_host_seq.md
TIMER_HOST_SEQ -- requirements
Module: timer_host_seq

Interface
REQ-001 SHALL have parameter PERIOD, default 32'h02FAF07F, timer load value (period minus one) programmed at start.
REQ-002 SHALL have parameter CONTINUOUS, default 1; 1 = timer reloads forever, 0 = one-shot.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to program and run the timer.
REQ-006 SHALL have port stop  input  1  single-cycle request to halt the timer.
REQ-007 SHALL have port tm_address  output  3  timer register address.
REQ-008 SHALL have port tm_chipselect  output  1  timer select.
REQ-009 SHALL have port tm_write_n  output  1  active-low write.
REQ-010 SHALL have port tm_writedata  output  16  write data.
REQ-011 SHALL have port tm_readdata  input  16  timer read data, valid one cycle after address.
REQ-012 SHALL have port tm_irq  input  1  timer interrupt, level.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port tick  output  1  one-cycle pulse per serviced timeout.
REQ-015 SHALL have port tick_count  output  16  number of serviced timeouts, wraps.
REQ-016 SHALL have port snapshot  output  32  last captured counter snapshot.

Function
REQ-017 SHALL act as the Avalon-MM initiator for the interval timer register map: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
REQ-018 SHALL perform every bus access as exactly one cycle with tm_chipselect=1; the target has no waitrequest.
REQ-019 SHALL hold tm_chipselect=0, tm_write_n=1, tm_address=0 and tm_writedata=0 when not accessing.
REQ-020 SHALL use states IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR_STAT, SNAP, RD_SL, RD_SH, TICK, WR_STOP.
REQ-021 SHALL go IDLE->WR_PL on start; no other input is required.
REQ-022 SHALL write PERIOD[15:0] to address 2 in WR_PL and PERIOD[31:16] to address 3 in WR_PH.
REQ-023 SHALL write control in WR_CTRL as {stop=0, start=1, cont=CONTINUOUS, ito=1}, i.e. 0x7 or 0x5.
REQ-024 SHALL wait in WAIT_IRQ until tm_irq=1, then go to CLR_STAT.
REQ-025 SHALL write 0 to address 0 in CLR_STAT.
REQ-026 SHALL, with snapshot enabled, write 0 to address 4 in SNAP.
REQ-027 SHALL drive address 4 (read) in RD_SL and capture tm_readdata into snapshot[15:0] in the following cycle.
REQ-028 SHALL drive address 5 in RD_SH and capture snapshot[31:16] in the cycle after RD_SH (TICK).
REQ-029 SHALL in TICK pulse tick, increment tick_count modulo 2^16, then return to WAIT_IRQ when CONTINUOUS=1, else go to IDLE.
REQ-030 SHALL make the latency from start to the period_l write 1 cycle.
REQ-031 SHALL latch stop in any non-IDLE state and honour it at the end of the current bus access; WAIT_IRQ exits to WR_STOP immediately.
REQ-032 SHALL in WR_STOP write 0x8 to address 1, clear the pending stop, then go to IDLE.
REQ-033 SHALL give stop priority over tm_irq when both are asserted in the same cycle in WAIT_IRQ.
REQ-034 SHALL ignore start while busy, and ignore stop in IDLE.
REQ-035 SHALL clear tm_irq within 3 cycles of its assertion (WAIT_IRQ->CLR_STAT), so that a next timeout is not lost when PERIOD >= 8.

Reset
REQ-036 SHALL on reset_n low immediately enter IDLE with all outputs 0 except tm_write_n=1, and clear the pending stop.
REQ-037 SHALL, after a reset mid-sequence, issue no further bus access until a new start.

Configuration
REQ-038 SHALL, when TIMER_HOST_SNAPSHOT_EN is defined, include SNAP/RD_SL/RD_SH and the snapshot register.
REQ-039 SHALL, when TIMER_HOST_SNAPSHOT_EN is undefined, go CLR_STAT->TICK directly and tie snapshot to 0.

Structure
REQ-040 SHALL place the state enum, register address constants (ADDR_STATUS..ADDR_SNAP_H) and control bit positions in package timer_host_pkg.
REQ-041 SHALL be a single module with no sub-modules; the bus output register is inline.

Verification
REQ-042 SHALL check programming: start with PERIOD=99 -> writes (2,0x0063),(3,0x0000),(1,0x0007) on consecutive cycles, then busy=1 and bus idle.
REQ-043 SHALL check a timeout: assert tm_irq -> write (0,0), snap writes/reads, tick=1 once, tick_count=1, snapshot equals the model value 0x0000_0062.
REQ-044 SHALL check stop: stop during WAIT_IRQ with simultaneous tm_irq -> only write (1,0x0008), then IDLE, tick never pulses.
REQ-045 SHALL check one-shot: CONTINUOUS=0 -> control 0x0005, single tick, then IDLE with busy=0.
REQ-046 SHALL check reset: reset_n low during RD_SL -> outputs 0 and tm_write_n=1 at once; no access until the next start.
REQ-047 SHALL check the macro-off build: without TIMER_HOST_SNAPSHOT_EN, timeout -> write (0,0), tick on the next cycle, snapshot=0.
